// File: rtl/grid_draw_scheduler.sv
// rtl/grid_draw_scheduler.sv - shadow-compare scheduler feeding the 30x30 block drawer (optional PLAYHEAD_EN)
module grid_draw_scheduler #(
    parameter int TRACKS        = 4,
    parameter int STEPS         = 16,
    parameter int X0            = 40,
    parameter int Y0            = 40,
    parameter int PITCH         = 36,
    parameter int START_TIMEOUT = 4
) (
    input  logic                       CLOCK_50,
    input  logic                       nReset,
    input  logic [TRACKS*STEPS-1:0]    pattern,
    input  logic                       refresh,
    input  logic [$clog2(STEPS)-1:0]   playhead,
    input  logic                       drawing,
    output logic                       draw_enable,
    output logic [9:0]                 draw_x,
    output logic [8:0]                 draw_y,
    output logic                       draw_state,
    output logic                       busy,
    output logic                       clean
);

    localparam int N  = TRACKS * STEPS;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [PW-1:0] LAST_CELL  = PW'(N - 1);
    localparam logic [TW-1:0] LAST_TICK  = TW'(START_TIMEOUT - 1);
    localparam logic [PW-1:0] STEPS_W    = PW'(STEPS);

    typedef enum logic [1:0] {SCAN, ISSUE, WAIT_START, WAIT_DONE} state_t;

    state_t        state;
    logic [N-1:0]  shadow;
    logic [N-1:0]  dirty;
    logic [N-1:0]  want;
    logic [N-1:0]  need;
    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] ptr_inc;
    logic [PW-1:0] idx_inc;
    logic [PW-1:0] col;
    logic [PW-1:0] row;
    logic [TW-1:0] timer;

`ifdef PLAYHEAD_EN
    // Wanted colour: pattern with the playhead column shown inverted
    always_comb begin
        want = '0;
        for (int i = 0; i < N; i++) begin
            want[i] = pattern[i] ^ ((i % STEPS) == int'(playhead));
        end
    end
`else
    logic unused_playhead;
    assign unused_playhead = ^playhead;
    assign want = pattern;
`endif

    assign need    = dirty | (shadow ^ want);
    assign ptr_inc = (ptr == LAST_CELL) ? '0 : ptr + PW'(1);
    assign idx_inc = (idx == LAST_CELL) ? '0 : idx + PW'(1);
    assign col     = ptr % STEPS_W;
    assign row     = ptr / STEPS_W;

    // Scan / issue / wait sequencer; draw_x, draw_y, draw_state are frozen while a cell is in flight
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state       <= SCAN;
            ptr         <= '0;
            idx         <= '0;
            timer       <= '0;
            shadow      <= '0;
            dirty       <= '1;
            draw_enable <= 1'b0;
            draw_x      <= '0;
            draw_y      <= '0;
            draw_state  <= 1'b0;
            busy        <= 1'b0;
            clean       <= 1'b0;
        end else begin
            draw_enable <= 1'b0;
            clean       <= 1'b0;
            case (state)
                SCAN: begin
                    if (need[ptr]) begin
                        idx         <= ptr;
                        draw_state  <= want[ptr];
                        draw_x      <= 10'(X0 + int'(col) * PITCH);
                        draw_y      <= 9'(Y0 + int'(row) * PITCH);
                        draw_enable <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end else begin
                        ptr   <= ptr_inc;
                        clean <= (need == '0);
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_START;
                end
                WAIT_START: begin
                    if (drawing) begin
                        state <= WAIT_DONE;
                    end else if (timer == LAST_TICK) begin
                        // Drawer never started: leave the cell unfinished and retry it
                        ptr   <= idx;
                        busy  <= 1'b0;
                        state <= SCAN;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!drawing) begin
                        shadow[idx] <= draw_state;
                        dirty[idx]  <= 1'b0;
                        ptr         <= idx_inc;
                        busy        <= 1'b0;
                        state       <= SCAN;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= SCAN;
                end
            endcase
            // A refresh overrides a completion landing in the same cycle
            if (refresh) begin
                dirty <= '1;
            end
        end
    end

endmodule

// File: tb/tb_grid_draw_scheduler.sv
// tb/tb_grid_draw_scheduler.sv - scoreboard bench for grid_draw_scheduler with a behavioural drawer
`timescale 1ns/1ps
module tb_grid_draw_scheduler;

    localparam int N = 64;

    logic           CLOCK_50 = 1'b0;
    logic           nReset   = 1'b0;
    logic [N-1:0]   pattern  = '0;
    logic           refresh  = 1'b0;
    logic [3:0]     playhead = '0;
    logic           drawing  = 1'b0;
    logic           draw_enable;
    logic [9:0]     draw_x;
    logic [8:0]     draw_y;
    logic           draw_state;
    logic           busy;
    logic           clean;

    grid_draw_scheduler dut (
        .CLOCK_50    (CLOCK_50),
        .nReset      (nReset),
        .pattern     (pattern),
        .refresh     (refresh),
        .playhead    (playhead),
        .drawing     (drawing),
        .draw_enable (draw_enable),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_state  (draw_state),
        .busy        (busy),
        .clean       (clean)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        int   idx;
        logic st;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         pulses = 0;
    int         last_pulse_cyc = 0;
    int         prev_pulse_cyc = 0;
    int         draw_len = 20;
    bit         block = 1'b0;
    bit         unordered = 1'b0;
    int         refresh_on_pulse = -1;
    int         hold_cnt = 0;
    int         cur_pulse = 0;
    logic [9:0] x_at17 = '0;
    logic [8:0] y_at17 = '0;

    function automatic int exp_x(input int i);
        return 40 + (i % 16) * 36;
    endfunction

    function automatic int exp_y(input int i);
        return 40 + (i / 16) * 36;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    always @(posedge CLOCK_50) cyc++;

    // Pulse monitor against the scoreboard, then the drawer model
    always @(negedge CLOCK_50) begin
        refresh = 1'b0;
        if (nReset && draw_enable) begin
            exp_t e;
            int   k;
            pulses++;
            prev_pulse_cyc = last_pulse_cyc;
            last_pulse_cyc = cyc;
            check("busy_in_issue", busy, 1);
            if (pulses == 18) begin
                x_at17 = draw_x;
                y_at17 = draw_y;
            end
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_queue_depth", 0, 1);
            end else if (unordered) begin
                k = -1;
                for (int j = 0; j < exp_q.size(); j++) begin
                    if (k < 0 && exp_x(exp_q[j].idx) == int'(draw_x) && exp_y(exp_q[j].idx) == int'(draw_y))
                        k = j;
                end
                check("unordered_cell_found", k >= 0, 1);
                if (k >= 0) begin
                    check("unordered_state", draw_state, exp_q[k].st);
                    exp_q.delete(k);
                end
            end else begin
                e = exp_q.pop_front();
                check("pulse_x", draw_x, exp_x(e.idx));
                check("pulse_y", draw_y, exp_y(e.idx));
                check("pulse_state", draw_state, e.st);
            end
        end
        if (!nReset) begin
            drawing  = 1'b0;
            hold_cnt = 0;
        end else if (drawing) begin
            hold_cnt++;
            if (hold_cnt >= draw_len) begin
                drawing = 1'b0;
                if (cur_pulse == refresh_on_pulse) refresh = 1'b1;
            end
        end else if (draw_enable && !block) begin
            drawing   = 1'b1;
            hold_cnt  = 0;
            cur_pulse = pulses;
        end
    end

    task automatic wait_pulses(input int target, input int budget, input string tag);
        int n = 0;
        while (pulses < target && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(tag, pulses >= target, 1);
    endtask

    task automatic wait_clean(input int budget, input string tag);
        int n = 0;
        while (clean !== 1'b1 && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(tag, clean, 1);
    endtask

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        repeat (3) @(negedge CLOCK_50);
        check("rst_draw_enable", draw_enable, 0);
        check("rst_draw_x", draw_x, 0);
        check("rst_draw_y", draw_y, 0);
        check("rst_draw_state", draw_state, 0);
        check("rst_busy", busy, 0);
        check("rst_clean", clean, 0);
`ifndef PLAYHEAD_EN
        // Full initial pass: every cell dirty, all blue, in index order
        for (int i = 0; i < N; i++) begin
            e.idx = i; e.st = 1'b0; exp_q.push_back(e);
        end
        nReset = 1'b1;
        @(negedge CLOCK_50);
        check("clean_after_release", clean, 0);
        wait_pulses(64, 4000, "init_pass_pulses");
        wait_clean(200, "init_clean");
        check("idx17_x", x_at17, 76);
        check("idx17_y", y_at17, 76);
        check("init_queue_empty", exp_q.size(), 0);
        check("busy_when_clean", busy, 0);

        // Single cell change, then a toggle back during its long draw
        draw_len = 961;
        e.idx = 5; e.st = 1'b1; exp_q.push_back(e);
        pattern[5] = 1'b1;
        wait_pulses(65, 100, "p5_pulse");
        repeat (5) @(negedge CLOCK_50);
        pattern[5] = 1'b0;
        e.idx = 5; e.st = 1'b0; exp_q.push_back(e);
        repeat (100) @(negedge CLOCK_50);
        check("p5_hold_x", draw_x, 220);
        check("p5_hold_y", draw_y, 40);
        check("p5_hold_state", draw_state, 1);
        check("p5_hold_busy", busy, 1);
        wait_pulses(66, 1200, "p5_redraw_pulse");
        wait_clean(1200, "p5_clean");
        repeat (50) @(negedge CLOCK_50);
        check("p5_no_extra", pulses, 66);
        check("p5_queue_empty", exp_q.size(), 0);
        draw_len = 20;

        // Drawer blocked: start timeout and retry of the same cell
        block = 1'b1;
        e.idx = 10; e.st = 1'b1; exp_q.push_back(e); exp_q.push_back(e);
        pattern[10] = 1'b1;
        wait_pulses(67, 100, "to_first_pulse");
        wait_pulses(68, 100, "to_retry_pulse");
        check("to_retry_gap", last_pulse_cyc - prev_pulse_cyc, 6);
        check("to_clean_low", clean, 0);
        e.idx = 10; e.st = 1'b1; exp_q.push_back(e);
        block = 1'b0;
        wait_pulses(69, 100, "to_release_pulse");
        wait_clean(200, "to_clean");
        repeat (20) @(negedge CLOCK_50);
        check("to_no_extra", pulses, 69);
        check("to_queue_empty", exp_q.size(), 0);

        // Refresh coincident with completion of idx 9: full pass ending with idx 9
        e.idx = 9; e.st = 1'b1; exp_q.push_back(e);
        refresh_on_pulse = 70;
        pattern[9] = 1'b1;
        for (int k = 1; k <= N; k++) begin
            e.idx = (9 + k) % N; e.st = pattern[(9 + k) % N]; exp_q.push_back(e);
        end
        wait_pulses(70 + N, 4000, "refresh_pass_pulses");
        wait_clean(200, "refresh_clean");
        repeat (20) @(negedge CLOCK_50);
        check("refresh_total_pulses", pulses, 70 + N);
        check("refresh_queue_empty", exp_q.size(), 0);
`else
        // Playhead on column 3: that column drawn white in the initial pass
        playhead = 4'd3;
        for (int i = 0; i < N; i++) begin
            e.idx = i; e.st = ((i % 16) == 3); exp_q.push_back(e);
        end
        nReset = 1'b1;
        wait_pulses(64, 4000, "ph_init_pulses");
        wait_clean(200, "ph_init_clean");
        check("ph_idx17_x", x_at17, 76);
        check("ph_idx17_y", y_at17, 76);
        check("ph_init_queue_empty", exp_q.size(), 0);
        // Move to column 4: old column back to blue, new column white
        unordered = 1'b1;
        for (int r = 0; r < 4; r++) begin
            e.idx = r * 16 + 3; e.st = 1'b0; exp_q.push_back(e);
            e.idx = r * 16 + 4; e.st = 1'b1; exp_q.push_back(e);
        end
        playhead = 4'd4;
        wait_pulses(72, 1000, "ph_move_pulses");
        wait_clean(200, "ph_move_clean");
        repeat (20) @(negedge CLOCK_50);
        check("ph_move_total", pulses, 72);
        check("ph_move_queue_empty", exp_q.size(), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
